// File: rtl/bean_scheduler.sv
// bean_scheduler
// Manages the pool of bean obstacle slots for the goose-run playfield. After a
// pseudo-random gap it spawns a bean at the right edge. Once per video frame it
// scrolls every live bean left. Beans that reach the left edge are retired and
// counted.
//
// Ports
//   clk          system (pixel) clock
//   rst          asynchronous, active-high reset
//   frame_tick   one-cycle pulse per video frame
//   run          level, 1 = game running, 0 = idle / cleared
//   halt         collision; freezes the field until run drops
//   bean_x       slot i left-edge x at bits [10i+9:10i]
//   bean_valid   slot i occupied
//   spawn_pulse  high for the cycle in which a newly spawned bean first appears
//   passed       beans retired in the current game, saturating at 0xFFFF

module bean_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SPAWN_X   = 400,
    parameter int SPEED     = 5,
    parameter int MIN_GAP   = 40,
    parameter int GAP_MASK  = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     run,
    input  logic                     halt,
    output logic [10*NUM_SLOTS-1:0]  bean_x,
    output logic [NUM_SLOTS-1:0]     bean_valid,
    output logic                     spawn_pulse,
    output logic [15:0]              passed
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam logic [9:0] SPEED_C   = 10'(SPEED);
    localparam logic [9:0] SPAWN_C   = 10'(SPAWN_X);
    localparam logic [8:0] MIN_GAP_C = 9'(MIN_GAP);
    localparam logic [7:0] MASK_C    = 8'(GAP_MASK);

    logic [1:0]             state;
    logic [15:0]            lfsr;
    logic [8:0]             gap_cnt;

    logic [10*NUM_SLOTS-1:0] next_x;
    logic [NUM_SLOTS-1:0]    next_valid;
    logic [NUM_SLOTS-1:0]    free_sel;
    logic                    free_found;
    logic [3:0]              retire_cnt;
    logic                    do_spawn;
    logic [8:0]              gap_reload;
    logic [8:0]              next_gap;
    logic [16:0]             passed_sum;
    logic [15:0]             next_passed;

    // Free-running Fibonacci LFSR with taps 16,14,13,11. It starts from a
    // non-zero seed, so it can never lock up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign gap_reload = MIN_GAP_C + {1'b0, lfsr[7:0] & MASK_C};

    // Next-frame image of the field. The free slot is chosen from the occupancy
    // before scrolling, so a slot retired on this tick cannot be reused until
    // the next tick. A new bean is written over the scrolled value, so it does
    // not move on its spawn tick.
    always_comb begin
        next_x     = bean_x;
        next_valid = bean_valid;
        retire_cnt = '0;
        free_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bean_valid[i]) begin
                if (bean_x[10*i +: 10] <= SPEED_C) begin
                    next_valid[i]      = 1'b0;
                    next_x[10*i +: 10] = '0;
                    retire_cnt         = retire_cnt + 4'd1;
                end else begin
                    next_x[10*i +: 10] = bean_x[10*i +: 10] - SPEED_C;
                end
            end else if (!free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end

        do_spawn = (gap_cnt == 9'd0) && free_found;
        if (do_spawn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (free_sel[i]) begin
                    next_x[10*i +: 10] = SPAWN_C;
                    next_valid[i]      = 1'b1;
                end
            end
        end

        // With a full pool the counter waits at zero, so the spawn is retried
        // on every later tick.
        if (gap_cnt != 9'd0) begin
            next_gap = gap_cnt - 9'd1;
        end else if (do_spawn) begin
            next_gap = gap_reload;
        end else begin
            next_gap = 9'd0;
        end

        passed_sum  = {1'b0, passed} + {13'd0, retire_cnt};
        next_passed = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];
    end

    // Game state machine. Priority within a cycle: run low clears the field,
    // then halt freezes it, then frame_tick advances it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bean_x      <= '0;
            bean_valid  <= '0;
            spawn_pulse <= 1'b0;
            passed      <= '0;
            gap_cnt     <= MIN_GAP_C;
        end else begin
            spawn_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bean_x     <= '0;
                    bean_valid <= '0;
                    passed     <= '0;
                    gap_cnt    <= MIN_GAP_C;
                    if (run) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state      <= ST_IDLE;
                        bean_x     <= '0;
                        bean_valid <= '0;
                        passed     <= '0;
                        gap_cnt    <= MIN_GAP_C;
                    end else if (halt) begin
                        state <= ST_FROZEN;
                    end else if (frame_tick) begin
                        bean_x      <= next_x;
                        bean_valid  <= next_valid;
                        passed      <= next_passed;
                        gap_cnt     <= next_gap;
                        spawn_pulse <= do_spawn;
                    end
                end
                ST_FROZEN: begin
                    if (!run) begin
                        state      <= ST_IDLE;
                        bean_x     <= '0;
                        bean_valid <= '0;
                        passed     <= '0;
                        gap_cnt    <= MIN_GAP_C;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bean_scheduler.sv
// tb_bean_scheduler
// Self-checking bench for bean_scheduler. The dut instance is a small
// two-slot configuration with a fixed spawn period. It covers spawn timing, a
// full pool, retirement, halt/freeze, async reset and saturation of passed.
// The dut6 instance uses the random gap. Its spawn intervals are checked
// against a reference LFSR kept in the bench.

module tb_bean_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic [19:0] bean_x;
    logic [1:0]  bean_valid;
    logic        spawn_pulse;
    logic [15:0] passed;

    logic        run6 = 1'b0;
    logic        tick6 = 1'b0;
    logic [39:0] bean_x6;
    logic [3:0]  bean_valid6;
    logic        spawn_pulse6;
    logic [15:0] passed6;

    logic [15:0] lfsr_m;

    int n_cmp = 0;
    int n_err = 0;
    int tick_no = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // Reference LFSR, used only to predict the random spawn gaps of dut6.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    bean_scheduler #(.NUM_SLOTS(2), .SPAWN_X(400), .SPEED(5), .MIN_GAP(3), .GAP_MASK(0)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .run(run), .halt(halt),
        .bean_x(bean_x), .bean_valid(bean_valid), .spawn_pulse(spawn_pulse), .passed(passed)
    );

    bean_scheduler #(.NUM_SLOTS(4), .SPAWN_X(400), .SPEED(5), .MIN_GAP(40), .GAP_MASK(63)) dut6 (
        .clk(clk), .rst(rst), .frame_tick(tick6), .run(run6), .halt(1'b0),
        .bean_x(bean_x6), .bean_valid(bean_valid6), .spawn_pulse(spawn_pulse6), .passed(passed6)
    );

    // One frame tick. On return the update is visible on the outputs.
    task automatic do_tick;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        tick_no++;
    endtask

    task automatic start_game;
        @(negedge clk);
        rst = 1'b1; run = 1'b0; halt = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0; run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick_no = 0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (bean_valid !== 2'b00 || bean_x !== 20'd0 || spawn_pulse !== 1'b0 || passed !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got valid=%b x=%h sp=%b passed=%0d, expected all zero",
                     bean_valid, bean_x, spawn_pulse, passed);
        end
        n_cmp++;
        if (bean_valid6 !== 4'd0 || passed6 !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs6: got valid=%b passed=%0d, expected 0", bean_valid6, passed6);
        end
    endtask

    task automatic test_spawn_timing;
        int got;
        start_game();
        exp_q.push_back(4);
        exp_q.push_back(8);
        for (int t = 1; t <= 9; t++) begin
            do_tick();
            if (spawn_pulse === 1'b1) begin
                n_cmp++;
                got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                if (got != tick_no) begin
                    n_err++;
                    $display("[TB] FAIL spawn_tick: spawn at tick %0d, expected tick %0d", tick_no, got);
                end
            end
            if (tick_no == 4) begin
                n_cmp++;
                if (bean_valid !== 2'b01 || bean_x[9:0] !== 10'd400) begin
                    n_err++;
                    $display("[TB] FAIL first_spawn: valid=%b x0=%0d, expected 01 / 400", bean_valid, bean_x[9:0]);
                end
            end
            if (tick_no == 5) begin
                n_cmp++;
                if (bean_x[9:0] !== 10'd395 || spawn_pulse !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL scroll_once: x0=%0d sp=%b, expected 395 / 0", bean_x[9:0], spawn_pulse);
                end
            end
            if (tick_no == 8) begin
                n_cmp++;
                if (bean_valid !== 2'b11 || bean_x[19:10] !== 10'd400 || bean_x[9:0] !== 10'd380) begin
                    n_err++;
                    $display("[TB] FAIL second_spawn: valid=%b x1=%0d x0=%0d, expected 11 / 400 / 380",
                             bean_valid, bean_x[19:10], bean_x[9:0]);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL spawn_missing: %0d expected spawns not seen, expected 0", exp_q.size());
        end
    endtask

    task automatic test_pool_full;
        int got;
        exp_q.push_back(85);
        while (tick_no < 85) begin
            do_tick();
            if (spawn_pulse === 1'b1) begin
                n_cmp++;
                got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                if (got != tick_no) begin
                    n_err++;
                    $display("[TB] FAIL full_spawn_tick: spawn at tick %0d, expected tick %0d", tick_no, got);
                end
            end
            if (tick_no == 12) begin
                n_cmp++;
                if (spawn_pulse !== 1'b0 || bean_valid !== 2'b11) begin
                    n_err++;
                    $display("[TB] FAIL pool_full: sp=%b valid=%b, expected 0 / 11", spawn_pulse, bean_valid);
                end
            end
            if (tick_no == 83) begin
                n_cmp++;
                if (bean_x[9:0] !== 10'd5) begin
                    n_err++;
                    $display("[TB] FAIL x_at_83: x0=%0d, expected 5", bean_x[9:0]);
                end
            end
            if (tick_no == 84) begin
                n_cmp++;
                if (bean_valid !== 2'b10 || bean_x[9:0] !== 10'd0 || passed !== 16'd1 || spawn_pulse !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL retire_84: valid=%b x0=%0d passed=%0d sp=%b, expected 10 / 0 / 1 / 0",
                             bean_valid, bean_x[9:0], passed, spawn_pulse);
                end
            end
            if (tick_no == 85) begin
                n_cmp++;
                if (bean_valid !== 2'b11 || bean_x[9:0] !== 10'd400) begin
                    n_err++;
                    $display("[TB] FAIL respawn_85: valid=%b x0=%0d, expected 11 / 400", bean_valid, bean_x[9:0]);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL full_spawn_missing: %0d expected spawns not seen, expected 0", exp_q.size());
        end
    endtask

    // Continues from tick 85. Slot 1 retires at tick 88 and slot 0 at tick 165.
    task automatic test_saturation;
        @(negedge clk);
        force dut.passed = 16'hFFFE;
        @(negedge clk);
        release dut.passed;
        while (tick_no < 165) begin
            do_tick();
            if (tick_no == 87) begin
                n_cmp++;
                if (passed !== 16'hFFFE) begin
                    n_err++;
                    $display("[TB] FAIL preload_hold: passed=%h, expected fffe", passed);
                end
            end
            if (tick_no == 88) begin
                n_cmp++;
                if (passed !== 16'hFFFF || bean_valid !== 2'b01) begin
                    n_err++;
                    $display("[TB] FAIL reach_max: passed=%h valid=%b, expected ffff / 01", passed, bean_valid);
                end
            end
        end
        n_cmp++;
        if (passed !== 16'hFFFF || bean_valid !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL saturate: passed=%h valid=%b, expected ffff / 10", passed, bean_valid);
        end
    endtask

    task automatic test_halt_freeze;
        start_game();
        for (int t = 1; t <= 10; t++) do_tick();
        @(negedge clk) begin halt = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin halt = 1'b0; frame_tick = 1'b0; end
        for (int t = 0; t <= 20; t++) begin
            n_cmp++;
            if (bean_valid !== 2'b11 || bean_x !== {10'd390, 10'd370} || passed !== 16'd0 || spawn_pulse !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL frozen_%0d: valid=%b x1=%0d x0=%0d passed=%0d sp=%b, expected 11 / 390 / 370 / 0 / 0",
                         t, bean_valid, bean_x[19:10], bean_x[9:0], passed, spawn_pulse);
            end
            if (t < 20) do_tick();
        end
        @(negedge clk) run = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bean_valid !== 2'b00 || bean_x !== 20'd0 || passed !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL clear_after_run0: valid=%b x=%h passed=%0d, expected 0", bean_valid, bean_x, passed);
        end
        for (int t = 0; t < 6; t++) do_tick();
        n_cmp++;
        if (bean_valid !== 2'b00 || spawn_pulse !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL idle_no_spawn: valid=%b sp=%b, expected 00 / 0", bean_valid, spawn_pulse);
        end
    endtask

    task automatic test_async_reset;
        start_game();
        while (tick_no < 85) do_tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bean_valid !== 2'b00 || bean_x !== 20'd0 || passed !== 16'd0 || spawn_pulse !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_reset: valid=%b x=%h passed=%0d sp=%b, expected all zero",
                     bean_valid, bean_x, passed, spawn_pulse);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick_no = 0;
        for (int t = 1; t <= 4; t++) begin
            do_tick();
            n_cmp++;
            if (spawn_pulse !== (t == 4)) begin
                n_err++;
                $display("[TB] FAIL restart_spawn_t%0d: sp=%b, expected %0d", t, spawn_pulse, (t == 4));
            end
        end
        n_cmp++;
        if (bean_valid !== 2'b01 || bean_x[9:0] !== 10'd400) begin
            n_err++;
            $display("[TB] FAIL restart_bean: valid=%b x0=%0d, expected 01 / 400", bean_valid, bean_x[9:0]);
        end
    endtask

    task automatic test_random_gap;
        logic [15:0] lfsr_at;
        logic [3:0]  prev_valid;
        logic [3:0]  new_bits;
        int          last_spawn;
        int          interval;
        int          got;
        int          exp_passed;
        @(negedge clk) run6 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_q.push_back(41);
        last_spawn = 0;
        exp_passed = 0;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            tick6 = 1'b1;
            lfsr_at = lfsr_m;
            prev_valid = bean_valid6;
            n_cmp++;
            if (dut6.lfsr !== lfsr_m || lfsr_m == 16'd0) begin
                n_err++;
                $display("[TB] FAIL lfsr_t%0d: got %h, expected %h (non-zero)", t, dut6.lfsr, lfsr_m);
            end
            @(negedge clk);
            tick6 = 1'b0;
            if (spawn_pulse6 === 1'b1) begin
                interval = t - last_spawn;
                got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_cmp++;
                if (interval != got || interval < 41 || interval > 104) begin
                    n_err++;
                    $display("[TB] FAIL gap_interval: interval %0d at tick %0d, expected %0d (41..104)",
                             interval, t, got);
                end
                new_bits = bean_valid6 & ~prev_valid;
                for (int i = 0; i < 4; i++) begin
                    if (new_bits[i]) begin
                        n_cmp++;
                        if (bean_x6[10*i +: 10] !== 10'd400) begin
                            n_err++;
                            $display("[TB] FAIL spawn6_x: slot %0d x=%0d, expected 400", i, bean_x6[10*i +: 10]);
                        end
                    end
                end
                exp_q.push_back(40 + int'(lfsr_at[7:0] & 8'd63) + 1);
                if (t + 80 <= 200) exp_passed++;
                last_spawn = t;
            end
        end
        n_cmp++;
        if (passed6 !== 16'(exp_passed)) begin
            n_err++;
            $display("[TB] FAIL passed6: got %0d, expected %0d", passed6, exp_passed);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_timing();
        test_pool_full();
        test_saturation();
        test_halt_freeze();
        test_async_reset();
        test_random_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/bean_scheduler.md
Name: bean_scheduler

Overview:
Sequences the bean obstacles for the goose-run playfield. Owns a fixed pool of bean slots and spawns new beans at the right edge after a pseudo-random frame gap. Scrolls every live bean left by a fixed step once per video frame, and retires beans that leave the screen. Drives the per-slot x positions and valid flags consumed by the bean draw logic, and a passed-bean count consumed by the score logic.

Parameters:
NUM_SLOTS, 4, number of concurrent bean slots (1..8)
SPAWN_X, 400, x position (left edge) loaded into a newly spawned bean; must be < 1024
SPEED, 5, pixels subtracted from each live bean per frame tick; 1..63
MIN_GAP, 40, minimum frame ticks between spawns; 1..255
GAP_MASK, 63, mask applied to LFSR low bits to form the random extra gap; 0 gives a fixed period

Ports:
clk  input  1  system clock (pixel clock domain)
rst  input  1  asynchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame (vsync-derived)
run  input  1  level; 1 = game running, 0 = game idle/cleared
halt  input  1  level or pulse; collision detected, freezes the field
bean_x  output  10*NUM_SLOTS  slot i left-edge x at bits [10i+9:10i], registered
bean_valid  output  NUM_SLOTS  slot i occupied, registered
spawn_pulse  output  1  one-cycle pulse in the cycle a spawn is committed
passed  output  16  beans retired since the current game started, saturates at 0xFFFF

Behaviour:
- Reset (async, immediate): state IDLE; bean_x all 0; bean_valid 0; spawn_pulse 0; passed 0; gap_cnt = MIN_GAP; LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk cycle in all states. Never zero.
- States: IDLE, RUN, FROZEN. Priority each cycle: rst > run==0 > halt > frame_tick.
- IDLE: slots cleared, passed cleared, gap_cnt held at MIN_GAP. Goes to RUN in the cycle after run==1 is seen.
- run==0 in RUN or FROZEN: next cycle is IDLE with bean_valid=0, bean_x=0, passed=0, gap_cnt=MIN_GAP.
- RUN with halt==1: go to FROZEN. No update occurs that cycle, even if frame_tick is also 1.
- FROZEN: all outputs held; frame_tick ignored. Exit only via run==0 (then IDLE).
- RUN with frame_tick==1 and halt==0: single-cycle update; results are visible on outputs the next cycle.
  - Scroll, per valid slot: if x <= SPEED, clear valid, set x=0, count as retired; else x <= x - SPEED. 10-bit unsigned arithmetic, no wrap possible.
  - passed increases by the number of slots retired this tick, saturating at 0xFFFF.
  - Spawn: if gap_cnt != 0, decrement gap_cnt. If gap_cnt == 0, select the lowest-index slot that was free before this tick.
    - Slots freed by retirement in the same tick are not eligible.
    - If a free slot exists: load x=SPAWN_X, set valid, pulse spawn_pulse, and reload gap_cnt = MIN_GAP + (LFSR[7:0] & GAP_MASK) using the LFSR value of that cycle.
    - If no slot is free: no spawn, spawn_pulse stays 0, gap_cnt stays 0, and the spawn is retried on every subsequent tick.
  - A newly spawned bean does not scroll on its spawn tick.
- Spawn timing: the first spawn occurs on the (MIN_GAP+1)th tick after entering RUN. With GAP_MASK=0, the spawn period is MIN_GAP+1 ticks.
- gap_cnt is 9 bits wide (MIN_GAP + masked value ≤ 510).
- spawn_pulse is 1 for exactly the cycle following the spawning tick, aligned with the new bean_valid bit.

Test Plan:
Shared config for tests 1-5: NUM_SLOTS=2, SPAWN_X=400, SPEED=5, MIN_GAP=3, GAP_MASK=0.
1. Reset, run=1, apply ticks 1..5 -> spawn_pulse only after tick 4; bean_valid=01 and bean_x[9:0]=400 after tick 4; 395 after tick 5; second spawn into slot 1 after tick 8.
2. Run until the pool is full -> tick 12 produces no spawn_pulse. Slot 0 reads x=5 after tick 83 and retires at tick 84: valid[0]=0, passed=1, no spawn at tick 84. Tick 85 spawns into slot 0 with x=400.
3. halt=1 coincident with a frame_tick after tick 10 -> outputs unchanged across 20 further ticks. Then run=0 -> next cycle bean_valid=00, passed=0, state IDLE.
4. Assert rst mid-RUN with both slots live, asynchronously between clock edges -> outputs zero immediately. After release with run=1, the first spawn again occurs after tick 4.
5. Force passed to 0xFFFF (long run, or preload in simulation) and then retire a bean -> passed stays 0xFFFF.
6. GAP_MASK=63, MIN_GAP=40, 200 ticks -> every spawn-to-spawn interval lies in 41..104 ticks, and the LFSR is never 0.
